// File: rtl/sccb_reg_target_if.sv
// Host-side register port of the SCCB target: write strobes, read requests, busy.
// master = the SCCB target, slave = the register host.
interface sccb_reg_target_if;
  logic        reg_wr_en;
  logic [15:0] reg_wr_addr;
  logic [7:0]  reg_wr_data;
  logic        rd_req;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data;
  logic        busy;

  modport master (
    output reg_wr_en, reg_wr_addr, reg_wr_data,
    output rd_req, rd_addr, busy,
    input  rd_data
  );

  modport slave (
    input  reg_wr_en, reg_wr_addr, reg_wr_data,
    input  rd_req, rd_addr, busy,
    output rd_data
  );
endinterface

// File: rtl/sccb_reg_target.sv
// SCCB/I2C register target: 8-bit dev addr, 16-bit sub-address, auto-increment.
// Define SCCB_TARGET_READ_EN to build the read path (RDAT/MACK states).
module sccb_reg_target #(
  parameter logic [7:0] DEV_ADDR = 8'h78,
  parameter int         FILT_LEN = 3
) (
  input  logic              clk_25M,
  input  logic              camera_rst,
  input  logic              i2c_sclk,
  inout  wire               i2c_sdat,
  sccb_reg_target_if.master reg_if
);
  localparam int CW = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0] CMAX = CW'(FILT_LEN - 1);

  typedef enum logic [3:0] {
    IDLE, DEV, ACK_DEV, ADR_H, ACK_AH,
    ADR_L, ACK_AL, WDAT, ACK_WD
`ifdef SCCB_TARGET_READ_EN
    , RDAT, MACK
`endif
  } state_t;

  // index 0 = SCL, index 1 = SDA
  logic [1:0]    s1, s2, flt, fd;
  logic [CW-1:0] cnt [2];

  always_ff @(posedge clk_25M or posedge camera_rst) begin
    if (camera_rst) begin
      s1     <= '1;
      s2     <= '1;
      flt    <= '1;
      fd     <= '1;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      s1 <= {i2c_sdat, i2c_sclk};
      s2 <= s1;
      fd <= flt;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == flt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CMAX) begin
          flt[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  logic scl_rise, scl_fall, start_c, stop_c;
  assign scl_rise = flt[0] & ~fd[0];
  assign scl_fall = ~flt[0] & fd[0];
  assign start_c  = ~flt[1] & fd[1] & flt[0] & fd[0];
  assign stop_c   = flt[1] & ~fd[1] & flt[0] & fd[0];

  state_t      state, ack_next;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg, adr_h, adr_l;
  logic [15:0] pointer;
  logic        sda_oe;
  logic [7:0]  nbyte;
  logic        rx_state, byte_done;

  assign i2c_sdat  = sda_oe ? 1'b0 : 1'bz;
  assign nbyte     = {shreg[6:0], flt[1]};
  assign rx_state  = (state == DEV) || (state == ADR_H)
                  || (state == ADR_L) || (state == WDAT);
  assign byte_done = scl_rise && (bit_cnt == 3'd7);

`ifdef SCCB_TARGET_READ_EN
  logic rd_mode, rd_ld, nack;
`else
  logic unused_rd;
  assign unused_rd      = ^reg_if.rd_data;
  assign reg_if.rd_req  = 1'b0;
  assign reg_if.rd_addr = '0;
`endif

  always_comb begin
    ack_next = WDAT;
    unique case (1'b1)
      state == ACK_DEV: begin
        ack_next = ADR_H;
`ifdef SCCB_TARGET_READ_EN
        if (rd_mode) ack_next = RDAT;
`endif
      end
      state == ACK_AH: ack_next = ADR_L;
      default:         ack_next = WDAT;
    endcase
  end

  always_ff @(posedge clk_25M or posedge camera_rst) begin
    if (camera_rst) begin
      state              <= IDLE;
      bit_cnt            <= '0;
      shreg              <= '0;
      adr_h              <= '0;
      adr_l              <= '0;
      pointer            <= '0;
      sda_oe             <= 1'b0;
      reg_if.reg_wr_en   <= 1'b0;
      reg_if.reg_wr_addr <= '0;
      reg_if.reg_wr_data <= '0;
      reg_if.busy        <= 1'b0;
`ifdef SCCB_TARGET_READ_EN
      reg_if.rd_req      <= 1'b0;
      reg_if.rd_addr     <= '0;
      rd_mode            <= 1'b0;
      rd_ld              <= 1'b0;
      nack               <= 1'b0;
`endif
    end else begin
      reg_if.reg_wr_en <= 1'b0;
`ifdef SCCB_TARGET_READ_EN
      reg_if.rd_req <= 1'b0;
      rd_ld         <= 1'b0;
      // host data arrives the clk after rd_req; SCL is already low
      if (rd_ld) begin
        shreg   <= reg_if.rd_data;
        sda_oe  <= ~reg_if.rd_data[7];
        pointer <= pointer + 16'd1;
      end
`endif
      if (start_c) begin
        state   <= DEV;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
      end else if (stop_c) begin
        state       <= IDLE;
        sda_oe      <= 1'b0;
        reg_if.busy <= 1'b0;
      end else begin
        if (rx_state && scl_rise) begin
          shreg   <= nbyte;
          bit_cnt <= bit_cnt + 3'd1;
        end
        unique case (state)
          IDLE: ;
          DEV: if (byte_done) begin
            if (nbyte == DEV_ADDR) begin
              state       <= ACK_DEV;
              reg_if.busy <= 1'b1;
`ifdef SCCB_TARGET_READ_EN
              rd_mode     <= 1'b0;
            end else if (nbyte == (DEV_ADDR | 8'h01)) begin
              state       <= ACK_DEV;
              reg_if.busy <= 1'b1;
              rd_mode     <= 1'b1;
`endif
            end else begin
              state       <= IDLE;
              reg_if.busy <= 1'b0;
            end
          end
          ADR_H: if (byte_done) begin
            adr_h <= nbyte;
            state <= ACK_AH;
          end
          ADR_L: if (byte_done) begin
            adr_l <= nbyte;
            state <= ACK_AL;
          end
          WDAT: if (byte_done) begin
            reg_if.reg_wr_en   <= 1'b1;
            reg_if.reg_wr_addr <= pointer;
            reg_if.reg_wr_data <= nbyte;
            pointer            <= pointer + 16'd1;
            state              <= ACK_WD;
          end
          ACK_DEV, ACK_AH, ACK_AL, ACK_WD: if (scl_fall) begin
            sda_oe <= ~sda_oe;
            if (sda_oe) begin
              state   <= ack_next;
              bit_cnt <= '0;
              if (state == ACK_AL) pointer <= {adr_h, adr_l};
`ifdef SCCB_TARGET_READ_EN
              if (ack_next == RDAT) begin
                reg_if.rd_req  <= 1'b1;
                reg_if.rd_addr <= pointer;
                rd_ld          <= 1'b1;
              end
`endif
            end
          end
`ifdef SCCB_TARGET_READ_EN
          RDAT: if (scl_fall && !rd_ld) begin
            if (bit_cnt == 3'd7) begin
              sda_oe <= 1'b0;
              state  <= MACK;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shreg   <= {shreg[6:0], 1'b0};
              sda_oe  <= ~shreg[6];
            end
          end
          MACK: begin
            if (scl_rise) nack <= flt[1];
            if (scl_fall) begin
              if (nack) begin
                state       <= IDLE;
                reg_if.busy <= 1'b0;
              end else begin
                state          <= RDAT;
                bit_cnt        <= '0;
                reg_if.rd_req  <= 1'b1;
                reg_if.rd_addr <= pointer;
                rd_ld          <= 1'b1;
              end
            end
          end
`endif
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sccb_reg_target.sv
// Directed bench for sccb_reg_target: bus master model with open-drain SDA.
// Host read data is a fixed table keyed on rd_addr.
module tb_sccb_reg_target;
  logic clk_25M = 1'b0;
  logic camera_rst = 1'b1;
  logic scl_drv = 1'b1;
  logic sda_low = 1'b0;
  wire  sda;

  assign sda = sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  sccb_reg_target_if bus_if ();

  assign bus_if.rd_data = (bus_if.rd_addr == 16'h300A) ? 8'h56 :
                          (bus_if.rd_addr == 16'h300B) ? 8'h40 : 8'hEE;

  sccb_reg_target dut (
    .clk_25M    (clk_25M),
    .camera_rst (camera_rst),
    .i2c_sclk   (scl_drv),
    .i2c_sdat   (sda),
    .reg_if     (bus_if)
  );

  always #20 clk_25M = ~clk_25M;

  int errors = 0;
  int checks = 0;
  int q = 16;
  logic [15:0] wa [$];
  logic [7:0]  wd [$];
  logic [15:0] ra [$];
  logic dut_low = 1'b0;
  logic busy_seen = 1'b0;

  always @(negedge clk_25M) begin
    if (bus_if.reg_wr_en) begin
      wa.push_back(bus_if.reg_wr_addr);
      wd.push_back(bus_if.reg_wr_data);
    end
    if (bus_if.rd_req) ra.push_back(bus_if.rd_addr);
    if (bus_if.busy) busy_seen = 1'b1;
  end

  always @(posedge clk_25M)
    if (!sda_low && sda == 1'b0) dut_low = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wq(input int n);
    repeat (n) @(negedge clk_25M);
  endtask

  task automatic i2c_start;
    sda_low = 1'b0; wq(q);
    scl_drv = 1'b1; wq(q);
    sda_low = 1'b1; wq(q);
    scl_drv = 1'b0; wq(q);
  endtask

  task automatic i2c_stop;
    sda_low = 1'b1; wq(q);
    scl_drv = 1'b1; wq(q);
    sda_low = 1'b0; wq(2 * q);
  endtask

  task automatic put_bit(input logic b);
    sda_low = !b; wq(q);
    scl_drv = 1'b1; wq(2 * q);
    scl_drv = 1'b0; wq(q);
  endtask

  task automatic get_bit(output logic b);
    sda_low = 1'b0; wq(q);
    scl_drv = 1'b1; wq(q);
    b = sda; wq(q);
    scl_drv = 1'b0; wq(q);
  endtask

  task automatic send(input logic [7:0] d, input logic exp_ack,
                      input string tag);
    logic b;
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(b);
    chk(tag, {31'd0, !b}, {31'd0, exp_ack});
  endtask

  task automatic get_byte(input logic mack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(!mack);
  endtask

  task automatic clr;
    wa.delete(); wd.delete(); ra.delete();
    dut_low = 1'b0; busy_seen = 1'b0;
  endtask

  task automatic test1(input string p);
    clr();
    i2c_start();
    send(8'h78, 1'b1, {p, "_dev"});
    send(8'h31, 1'b1, {p, "_ah"});
    send(8'h03, 1'b1, {p, "_al"});
    send(8'h11, 1'b1, {p, "_d"});
    chk({p, "_busy"}, {31'd0, bus_if.busy}, 32'd1);
    i2c_stop();
    chk({p, "_busy_off"}, {31'd0, bus_if.busy}, 32'd0);
    chk({p, "_nwr"}, wa.size(), 32'd1);
    chk({p, "_addr"}, {16'd0, wa[0]}, 32'h3103);
    chk({p, "_data"}, {24'd0, wd[0]}, 32'h11);
  endtask

  initial begin
    logic [7:0] d;
    logic b;
    wq(5);
    chk("rst_sda", {31'd0, sda}, 32'd1);
    chk("rst_wr_en", {31'd0, bus_if.reg_wr_en}, 32'd0);
    chk("rst_wr_addr", {16'd0, bus_if.reg_wr_addr}, 32'd0);
    chk("rst_wr_data", {24'd0, bus_if.reg_wr_data}, 32'd0);
    chk("rst_rd_req", {31'd0, bus_if.rd_req}, 32'd0);
    chk("rst_rd_addr", {16'd0, bus_if.rd_addr}, 32'd0);
    chk("rst_busy", {31'd0, bus_if.busy}, 32'd0);
    camera_rst = 1'b0;
    wq(5);

    // single write at ~20 kHz
    q = 312;
    test1("t1");
    q = 16;

    // burst with auto-increment, then pointer wrap
    clr();
    i2c_start();
    send(8'h78, 1'b1, "t2_dev");
    send(8'h58, 1'b1, "t2_ah");
    send(8'h00, 1'b1, "t2_al");
    send(8'h23, 1'b1, "t2_d0");
    send(8'h14, 1'b1, "t2_d1");
    send(8'h0F, 1'b1, "t2_d2");
    i2c_stop();
    chk("t2_nwr", wa.size(), 32'd3);
    chk("t2_a0", {16'd0, wa[0]}, 32'h5800);
    chk("t2_a1", {16'd0, wa[1]}, 32'h5801);
    chk("t2_a2", {16'd0, wa[2]}, 32'h5802);
    chk("t2_d0v", {24'd0, wd[0]}, 32'h23);
    chk("t2_d1v", {24'd0, wd[1]}, 32'h14);
    chk("t2_d2v", {24'd0, wd[2]}, 32'h0F);
    chk("t2_ptr", {16'd0, dut.pointer}, 32'h5803);
    clr();
    i2c_start();
    send(8'h78, 1'b1, "t2w_dev");
    send(8'hFF, 1'b1, "t2w_ah");
    send(8'hFF, 1'b1, "t2w_al");
    send(8'hAA, 1'b1, "t2w_d0");
    send(8'hBB, 1'b1, "t2w_d1");
    i2c_stop();
    chk("t2w_nwr", wa.size(), 32'd2);
    chk("t2w_a0", {16'd0, wa[0]}, 32'hFFFF);
    chk("t2w_a1", {16'd0, wa[1]}, 32'h0000);
    chk("t2w_d1v", {24'd0, wd[1]}, 32'hBB);

    // foreign device address is ignored
    clr();
    i2c_start();
    send(8'h42, 1'b0, "t3_dev");
    send(8'h11, 1'b0, "t3_b0");
    send(8'h22, 1'b0, "t3_b1");
    send(8'h33, 1'b0, "t3_b2");
    i2c_stop();
    chk("t3_sda_low", {31'd0, dut_low}, 32'd0);
    chk("t3_nwr", wa.size(), 32'd0);
    chk("t3_busy", {31'd0, busy_seen}, 32'd0);

    // read path, or NACK of the read address
    clr();
`ifdef SCCB_TARGET_READ_EN
    i2c_start();
    send(8'h78, 1'b1, "t4_dev");
    send(8'h30, 1'b1, "t4_ah");
    send(8'h0A, 1'b1, "t4_al");
    i2c_start();
    send(8'h79, 1'b1, "t4_rdev");
    get_byte(1'b1, d);
    chk("t4_rd0", {24'd0, d}, 32'h56);
    get_byte(1'b0, d);
    chk("t4_rd1", {24'd0, d}, 32'h40);
    i2c_stop();
    chk("t4_nreq", ra.size(), 32'd2);
    chk("t4_ra0", {16'd0, ra[0]}, 32'h300A);
    chk("t4_ra1", {16'd0, ra[1]}, 32'h300B);
    chk("t4_nwr", wa.size(), 32'd0);
`else
    i2c_start();
    send(8'h79, 1'b0, "t4_nack");
    i2c_stop();
    chk("t4_nreq", ra.size(), 32'd0);
    chk("t4_busy", {31'd0, busy_seen}, 32'd0);
`endif
    chk("t4_busy_off", {31'd0, bus_if.busy}, 32'd0);

    // short SDA-low glitch at idle must not look like START
    clr();
    sda_low = 1'b1; wq(2);
    sda_low = 1'b0; wq(q);
    scl_drv = 1'b0; wq(q);
    send(8'h78, 1'b0, "t5g_noack");
    i2c_stop();
    chk("t5g_busy", {31'd0, busy_seen}, 32'd0);

    // short SDA-high glitch on a 0 data bit must not look like STOP
    clr();
    i2c_start();
    send(8'h78, 1'b1, "t5h_dev");
    send(8'h12, 1'b1, "t5h_ah");
    send(8'h34, 1'b1, "t5h_al");
    sda_low = 1'b1; wq(q);
    scl_drv = 1'b1; wq(q);
    sda_low = 1'b0; wq(2);
    sda_low = 1'b1; wq(q);
    scl_drv = 1'b0; wq(q);
    for (int i = 6; i >= 0; i--) put_bit(1'b0);
    get_bit(b);
    chk("t5h_ack", {31'd0, !b}, 32'd1);
    i2c_stop();
    chk("t5h_nwr", wa.size(), 32'd1);
    chk("t5h_addr", {16'd0, wa[0]}, 32'h1234);
    chk("t5h_data", {24'd0, wd[0]}, 32'h00);

    // STOP after 4 data bits discards the byte
    clr();
    i2c_start();
    send(8'h78, 1'b1, "t5s_dev");
    send(8'h20, 1'b1, "t5s_ah");
    send(8'h00, 1'b1, "t5s_al");
    put_bit(1'b1); put_bit(1'b0);
    put_bit(1'b1); put_bit(1'b0);
    i2c_stop();
    chk("t5s_nwr", wa.size(), 32'd0);
    chk("t5s_busy", {31'd0, bus_if.busy}, 32'd0);
    chk("t5s_sda", {31'd0, sda}, 32'd1);

    // reset while the target pulls the ACK low
    clr();
    i2c_start();
    d = 8'h78;
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    sda_low = 1'b0; wq(q);
    scl_drv = 1'b1; wq(q);
    chk("t6_ack_low", {31'd0, sda}, 32'd0);
    chk("t6_busy_pre", {31'd0, bus_if.busy}, 32'd1);
    camera_rst = 1'b1;
    #1;
    chk("t6_sda", {31'd0, sda}, 32'd1);
    chk("t6_busy", {31'd0, bus_if.busy}, 32'd0);
    chk("t6_wr_en", {31'd0, bus_if.reg_wr_en}, 32'd0);
    chk("t6_wr_addr", {16'd0, bus_if.reg_wr_addr}, 32'd0);
    chk("t6_wr_data", {24'd0, bus_if.reg_wr_data}, 32'd0);
    chk("t6_rd_req", {31'd0, bus_if.rd_req}, 32'd0);
    chk("t6_rd_addr", {16'd0, bus_if.rd_addr}, 32'd0);
    chk("t6_ptr", {16'd0, dut.pointer}, 32'd0);
    wq(4);
    camera_rst = 1'b0;
    wq(q);
    scl_drv = 1'b0; wq(q);
    i2c_stop();
    test1("t6r");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
